// File: rtl/d_cache_pkg.sv
// d_cache_pkg -- shared constants and FSM state encoding for the d_cache_wb
// write-back data cache.
//   ADDR_W  : CPU byte-address width
//   WORD_W  : CPU word width
//   state_t : controller states (IDLE, WRITEBACK, FILL)
package d_cache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_t;

endpackage

// File: rtl/d_cache_way.sv
// d_cache_way -- storage for one way of the cache: per-set valid, dirty, tag
// and data block, plus the tag compare for the currently indexed set.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (valid/dirty only)
//   idx                 : set index for lookup, store and fill
//   tag                 : request tag compared against the stored tag
//   word_sel            : word within the block for loads/stores
//   store_en/store_data : write one word and mark the line dirty
//   fill_en/fill_tag/fill_data : install a clean block from memory
//   hit, valid, dirty   : status of the indexed line
//   tag_out, block_out  : stored tag and block (victim writeback source)
//   word_out            : selected word of the indexed block
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int SET_BITS = 8,
  parameter int OFF_BITS = 2,
  localparam int SETS    = 1 << SET_BITS,
  localparam int BLOCK_W = WORD_W << OFF_BITS,
  localparam int TAG_W   = ADDR_W - SET_BITS - OFF_BITS - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] idx,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFF_BITS-1:0] word_sel,
  input  logic                store_en,
  input  logic [WORD_W-1:0]   store_data,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  output logic                hit,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag_out,
  output logic [BLOCK_W-1:0]  block_out,
  output logic [WORD_W-1:0]   word_out
);

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  // Status bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (store_en) begin
      data_q[idx][int'(word_sel)*WORD_W +: WORD_W] <= store_data;
    end
  end

  assign valid     = valid_q[idx];
  assign dirty     = dirty_q[idx];
  assign tag_out   = tag_q[idx];
  assign block_out = data_q[idx];
  assign word_out  = block_out[int'(word_sel)*WORD_W +: WORD_W];
  assign hit       = valid && (tag_out == tag);

endmodule

// File: rtl/d_cache_wb.sv
// d_cache_wb -- 2-way set-associative, write-back, write-allocate data cache.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_re/cpu_we            : load/store request (both high = store)
//   cpu_addr, cpu_wd, cpu_rd : word-aligned address, store data, load data
//   cpu_stall                : holds the CPU during a miss
//   mem_req/mem_we/mem_addr  : block transaction (1 = writeback, 0 = fill)
//   mem_wdata/mem_rdata      : victim block out, fill block in
//   mem_ready                : one-cycle completion pulse
//   hit_cnt/miss_cnt         : statistics counters
// Optional feature: define D_CACHE_STATS_EN to build the hit/miss counters;
// otherwise both outputs are tied to zero.
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int SET_BITS = 8,
  parameter int OFF_BITS = 2,
  localparam int SETS    = 1 << SET_BITS,
  localparam int BLOCK_W = WORD_W << OFF_BITS,
  localparam int TAG_W   = ADDR_W - SET_BITS - OFF_BITS - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wd,
  output logic [WORD_W-1:0]  cpu_rd,
  output logic               cpu_stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  state_t              state_q, state_d;
  logic [SETS-1:0]     lru_q;
  logic                vict_q;
  logic [SET_BITS-1:0] set_q;
  logic [TAG_W-1:0]    rtag_q;

  logic                req, any_hit, victim, hit_det, miss_det;
  logic [SET_BITS-1:0] addr_set, idx;
  logic [TAG_W-1:0]    addr_tag;
  logic [OFF_BITS-1:0] word_sel;
  logic [1:0]          hit_w, valid_w, dirty_w, store_en_w, fill_en_w;
  logic [TAG_W-1:0]    tag_w   [2];
  logic [BLOCK_W-1:0]  block_w [2];
  logic [WORD_W-1:0]   word_w  [2];
  logic                unused_addr_lsb;

  assign req             = cpu_re | cpu_we;
  assign addr_set        = cpu_addr[SET_BITS+OFF_BITS+1 : OFF_BITS+2];
  assign addr_tag        = cpu_addr[ADDR_W-1 : SET_BITS+OFF_BITS+2];
  assign word_sel        = cpu_addr[OFF_BITS+1 : 2];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // During a transaction the ways are indexed by the latched set so that the
  // victim block and tag stay put regardless of the CPU address bus.
  assign idx = (state_q == ST_IDLE) ? addr_set : set_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    d_cache_way #(
      .SET_BITS (SET_BITS),
      .OFF_BITS (OFF_BITS)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .idx        (idx),
      .tag        (addr_tag),
      .word_sel   (word_sel),
      .store_en   (store_en_w[w]),
      .store_data (cpu_wd),
      .fill_en    (fill_en_w[w]),
      .fill_tag   (rtag_q),
      .fill_data  (mem_rdata),
      .hit        (hit_w[w]),
      .valid      (valid_w[w]),
      .dirty      (dirty_w[w]),
      .tag_out    (tag_w[w]),
      .block_out  (block_w[w]),
      .word_out   (word_w[w])
    );
  end

  assign any_hit   = |hit_w;
  assign cpu_rd    = word_w[hit_w[1]];
  assign victim    = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[idx]);
  assign mem_wdata = block_w[vict_q];

  always_comb begin
    state_d    = state_q;
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    hit_det    = 1'b0;
    miss_det   = 1'b0;
    store_en_w = '0;
    fill_en_w  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (any_hit) begin
            hit_det = 1'b1;
            if (cpu_we) store_en_w = hit_w;
          end else begin
            cpu_stall = 1'b1;
            miss_det  = 1'b1;
            state_d   = (valid_w[victim] && dirty_w[victim]) ? ST_WRITEBACK : ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_w[vict_q], set_q, {(OFF_BITS+2){1'b0}}};
        if (mem_ready) state_d = ST_FILL;
      end
      ST_FILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {rtag_q, set_q, {(OFF_BITS+2){1'b0}}};
        if (mem_ready) begin
          fill_en_w[vict_q] = 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // LRU bit names the next victim: the way that did not just hit.
  always_ff @(posedge clk) begin
    if (rst)          lru_q <= '0;
    else if (hit_det) lru_q[idx] <= ~hit_w[1];
  end

  // Miss context captured once so the transaction ignores later bus activity.
  always_ff @(posedge clk) begin
    if (miss_det) begin
      vict_q <= victim;
      set_q  <= addr_set;
      rtag_q <= addr_tag;
    end
  end

`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_det)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_det) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_d_cache_wb.sv
// tb_d_cache_wb -- self-checking bench for d_cache_wb (SET_BITS=8, OFF_BITS=2).
// Reference: a flat word memory holding the latest value of every address,
// a backing-store model that services fills/writebacks, and a per-set
// residency model (which tags are cached, dirty, and which is next victim).
// Honours D_CACHE_STATS_EN to pick the expected counter values.
module tb_d_cache_wb;

  logic         clk = 1'b0;
  logic         rst, cpu_re, cpu_we, cpu_stall, mem_req, mem_we, mem_ready;
  logic [31:0]  cpu_addr, cpu_wd, cpu_rd, mem_addr, hit_cnt, miss_cnt;
  logic [127:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  d_cache_wb #(.SET_BITS(8), .OFF_BITS(2)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

`ifdef D_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic        m_valid [256][2];
  logic        m_dirty [256][2];
  logic [19:0] m_tag   [256][2];
  logic        m_lru   [256];
  int unsigned exp_hits, exp_misses;

  typedef struct {
    logic         first_stall;
    logic         idle_req;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         final_stall;
    logic [31:0]  rd;
  } obs_t;

  typedef struct {
    logic         hit;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_blk;
    logic [31:0]  rd;
  } exp_t;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [127:0] ref_block(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = ref_rd({a[31:4], 4'b0} + 32'(4*i));
    return b;
  endfunction

  // Residency + flat-memory update for one access; returns what should happen.
  task automatic model_step(input logic st, input logic [31:0] a, input logic [31:0] wd,
                            output exp_t e);
    int s, way;
    logic [19:0] t;
    s = int'(a[11:4]);
    t = a[31:12];
    e.hit = 1'b0; e.wb = 1'b0; e.wb_addr = '0; e.wb_blk = '0; way = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin e.hit = 1'b1; way = w; end
    if (!e.hit) begin
      if (!m_valid[s][0])      way = 0;
      else if (!m_valid[s][1]) way = 1;
      else                     way = m_lru[s] ? 1 : 0;
      if (m_valid[s][way] && m_dirty[s][way]) begin
        e.wb      = 1'b1;
        e.wb_addr = {m_tag[s][way], a[11:4], 4'b0};
        e.wb_blk  = ref_block(e.wb_addr);
      end
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = t;
      m_dirty[s][way] = 1'b0;
      exp_misses++;
    end
    e.rd = ref_rd(a);
    if (st) begin
      m_dirty[s][way] = 1'b1;
      ref_mem[a] = wd;
    end
    m_lru[s] = (way == 0);
    exp_hits++;
  endtask

  task automatic pulse_ready();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  // Drive one access, service memory, and record what the DUT did.
  task automatic do_access(input logic st, input logic both, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, output obs_t o);
    logic [31:0] base;
    cpu_re = !st || both; cpu_we = st; cpu_addr = a; cpu_wd = wd;
    o.wb = 1'b0; o.wb_addr = '0; o.wb_data = '0; o.fill_req = 1'b0; o.fill_addr = '0;
    @(negedge clk);
    o.first_stall = cpu_stall;
    o.idle_req    = mem_req;
    if (cpu_stall) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        o.wb = 1'b1; o.wb_addr = mem_addr; o.wb_data = mem_wdata;
        base = {mem_addr[31:4], 4'b0};
        for (int i = 0; i < 4; i++) bmem[base + 32'(4*i)] = mem_wdata[32*i +: 32];
        repeat (dly) @(negedge clk);
        pulse_ready();
        @(negedge clk);
      end
      o.fill_req  = mem_req && !mem_we;
      o.fill_addr = mem_addr;
      base = {mem_addr[31:4], 4'b0};
      for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = bmem_rd(base + 32'(4*i));
      repeat (dly) @(negedge clk);
      pulse_ready();
      @(negedge clk);
    end
    o.final_stall = cpu_stall;
    o.rd          = cpu_rd;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic access_m(input logic st, input logic both, input logic [31:0] a,
                          input logic [31:0] wd, input int dly, output obs_t o, output exp_t e);
    model_step(st, a, wd, e);
    do_access(st, both, a, wd, dly, o);
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0;
    cpu_addr = '0; cpu_wd = '0; mem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 256; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_tag[s][w] = '0; end
    end
    ref_mem.delete();
    foreach (bmem[k]) ref_mem[k] = bmem[k];
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    checks++; if (hit_cnt !== 32'd0) begin failures++; $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_miss_cnt got=%0d want=0", miss_cnt); end
    pulse_ready();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_ready_ignored mem_req got=%b want=0", mem_req); end
  endtask

  task automatic test_cold_miss();
    obs_t o; exp_t e;
    access_m(1'b0, 1'b0, 32'h0000_1004, 32'h0, 20, o, e);
    checks++; if (o.first_stall !== 1'b1) begin failures++; $display("FAIL cold_stall got=%b want=1", o.first_stall); end
    checks++; if (o.wb !== 1'b0) begin failures++; $display("FAIL cold_no_wb got=%b want=0", o.wb); end
    checks++; if (o.fill_req !== 1'b1) begin failures++; $display("FAIL cold_fill_req got=%b want=1", o.fill_req); end
    checks++; if (o.fill_addr !== 32'h0000_1000) begin failures++; $display("FAIL cold_fill_addr got=%h want=00001000", o.fill_addr); end
    checks++; if (o.final_stall !== 1'b0) begin failures++; $display("FAIL cold_release got=%b want=0", o.final_stall); end
    checks++; if (o.rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cold_rd got=%h want=deadbeef", o.rd); end
  endtask

  task automatic test_write_hit();
    obs_t o; exp_t e;
    access_m(1'b1, 1'b0, 32'h0000_1008, 32'h1234_5678, 0, o, e);
    checks++; if (o.first_stall !== 1'b0) begin failures++; $display("FAIL whit_stall got=%b want=0", o.first_stall); end
    checks++; if (o.idle_req !== 1'b0) begin failures++; $display("FAIL whit_mem_req got=%b want=0", o.idle_req); end
    access_m(1'b0, 1'b0, 32'h0000_1008, 32'h0, 0, o, e);
    checks++; if (o.rd !== 32'h1234_5678) begin failures++; $display("FAIL whit_readback got=%h want=12345678", o.rd); end
  endtask

  task automatic test_dirty_evict();
    obs_t o; exp_t e;
    access_m(1'b0, 1'b0, 32'h0000_2000, 32'h0, 1, o, e);
    checks++; if (o.wb !== 1'b0) begin failures++; $display("FAIL devict_2000_wb got=%b want=0", o.wb); end
    access_m(1'b0, 1'b0, 32'h0000_3000, 32'h0, 3, o, e);
    checks++; if (o.wb !== 1'b1) begin failures++; $display("FAIL devict_wb got=%b want=1", o.wb); end
    checks++; if (o.wb_addr !== 32'h0000_1000) begin failures++; $display("FAIL devict_wb_addr got=%h want=00001000", o.wb_addr); end
    checks++; if (o.wb_data[95:64] !== 32'h1234_5678) begin failures++; $display("FAIL devict_wb_word2 got=%h want=12345678", o.wb_data[95:64]); end
    checks++; if (o.wb_data !== e.wb_blk) begin failures++; $display("FAIL devict_wb_block got=%h want=%h", o.wb_data, e.wb_blk); end
    checks++; if (o.fill_addr !== 32'h0000_3000) begin failures++; $display("FAIL devict_fill_addr got=%h want=00003000", o.fill_addr); end
    checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL devict_rd got=%h want=%h", o.rd, e.rd); end
  endtask

  task automatic test_lru();
    obs_t o; exp_t e;
    do_reset();
    access_m(1'b0, 1'b0, 32'h0000_1000, 32'h0, 0, o, e);
    access_m(1'b0, 1'b0, 32'h0000_2000, 32'h0, 0, o, e);
    access_m(1'b0, 1'b0, 32'h0000_1000, 32'h0, 0, o, e);
    checks++; if (o.first_stall !== 1'b0) begin failures++; $display("FAIL lru_hit_1000 stall got=%b want=0", o.first_stall); end
    access_m(1'b0, 1'b0, 32'h0000_3000, 32'h0, 2, o, e);
    checks++; if (o.first_stall !== 1'b1) begin failures++; $display("FAIL lru_miss_3000 stall got=%b want=1", o.first_stall); end
    checks++; if (o.wb !== 1'b0) begin failures++; $display("FAIL lru_clean_no_wb got=%b want=0", o.wb); end
    checks++; if (o.fill_addr !== 32'h0000_3000) begin failures++; $display("FAIL lru_fill_addr got=%h want=00003000", o.fill_addr); end
    access_m(1'b0, 1'b0, 32'h0000_1000, 32'h0, 0, o, e);
    checks++; if (o.first_stall !== 1'b0) begin failures++; $display("FAIL lru_1000_kept stall got=%b want=0", o.first_stall); end
    access_m(1'b0, 1'b0, 32'h0000_2000, 32'h0, 0, o, e);
    checks++; if (o.first_stall !== 1'b1) begin failures++; $display("FAIL lru_2000_evicted stall got=%b want=1", o.first_stall); end
  endtask

  task automatic test_reset_mid_fill();
    obs_t o; exp_t e;
    do_reset();
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL midfill_in_fill req/we got=%b%b want=10", mem_req, mem_we); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midfill_req_dropped got=%b want=0", mem_req); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL midfill_remiss stall got=%b want=1", cpu_stall); end
    access_m(1'b0, 1'b0, 32'h0000_1000, 32'h0, 2, o, e);
    checks++; if (o.fill_addr !== 32'h0000_1000) begin failures++; $display("FAIL midfill_refill_addr got=%h want=00001000", o.fill_addr); end
    checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL midfill_rd got=%h want=%h", o.rd, e.rd); end
  endtask

  task automatic test_stats();
    obs_t o; exp_t e;
    do_reset();
    access_m(1'b0, 1'b0, 32'h0000_1000, 32'h0, 1, o, e);
    access_m(1'b0, 1'b0, 32'h0000_1004, 32'h0, 0, o, e);
    checks++; if (miss_cnt !== (STATS ? 32'd1 : 32'd0)) begin failures++; $display("FAIL stats_miss got=%0d want=%0d", miss_cnt, STATS ? 1 : 0); end
    checks++; if (hit_cnt !== (STATS ? 32'd2 : 32'd0)) begin failures++; $display("FAIL stats_hit got=%0d want=%0d", hit_cnt, STATS ? 2 : 0); end
  endtask

  // Random loads/stores (including re&we together) over a few conflicting
  // tags in four sets, issued back to back with random memory latency.
  task automatic test_random();
    obs_t o; exp_t e;
    logic st, both;
    logic [31:0] a, wd;
    int dly;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      st   = 1'($urandom_range(0, 1));
      both = st & 1'($urandom_range(0, 1));
      a    = {12'h0, 8'($urandom_range(1, 5)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      wd   = $urandom;
      dly  = int'($urandom_range(0, 4));
      access_m(st, both, a, wd, dly, o, e);
      checks++; if (o.first_stall !== !e.hit) begin failures++; $display("FAIL rnd_hitmiss n=%0d a=%h got_stall=%b want=%b", n, a, o.first_stall, !e.hit); end
      if (!e.hit) begin
        checks++; if (o.idle_req !== 1'b0) begin failures++; $display("FAIL rnd_idle_req n=%0d got=%b want=0", n, o.idle_req); end
        checks++; if (o.wb !== e.wb) begin failures++; $display("FAIL rnd_wb n=%0d got=%b want=%b", n, o.wb, e.wb); end
        if (e.wb) begin
          checks++; if (o.wb_addr !== e.wb_addr) begin failures++; $display("FAIL rnd_wb_addr n=%0d got=%h want=%h", n, o.wb_addr, e.wb_addr); end
          checks++; if (o.wb_data !== e.wb_blk) begin failures++; $display("FAIL rnd_wb_data n=%0d got=%h want=%h", n, o.wb_data, e.wb_blk); end
        end
        checks++; if (o.fill_req !== 1'b1 || o.fill_addr !== {a[31:4], 4'b0}) begin failures++; $display("FAIL rnd_fill n=%0d req=%b addr=%h want=1 %h", n, o.fill_req, o.fill_addr, {a[31:4], 4'b0}); end
      end
      checks++; if (o.final_stall !== 1'b0) begin failures++; $display("FAIL rnd_release n=%0d got=%b want=0", n, o.final_stall); end
      if (!st) begin
        checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL rnd_rd n=%0d a=%h got=%h want=%h", n, a, o.rd, e.rd); end
      end
    end
    checks++; if (hit_cnt !== (STATS ? 32'(exp_hits) : 32'd0)) begin failures++; $display("FAIL rnd_hit_cnt got=%0d want=%0d", hit_cnt, STATS ? exp_hits : 0); end
    checks++; if (miss_cnt !== (STATS ? 32'(exp_misses) : 32'd0)) begin failures++; $display("FAIL rnd_miss_cnt got=%0d want=%0d", miss_cnt, STATS ? exp_misses : 0); end
  endtask

  initial begin
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    bmem[32'h0000_1004] = 32'hDEAD_BEEF;
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_dirty_evict();
    test_lru();
    test_reset_mid_fill();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/d_cache_wb.md
D_CACHE_WB -- requirements
Module: d_cache_wb

Interface
REQ-001 SHALL have parameter SET_BITS, default 8, meaning log2 of the number of sets (set index = cpu_addr[SET_BITS+OFF_BITS+1 : OFF_BITS+2]).
REQ-002 SHALL have parameter OFF_BITS, default 2, meaning log2 of words per block; BLOCK_W = 32*2^OFF_BITS; tag = cpu_addr[31 : SET_BITS+OFF_BITS+2].
REQ-003 SHALL have ports as follows (one clock; reset is synchronous and active-high):
  clk  in  1  system clock, all state updates on posedge
  rst  in  1  synchronous active-high reset
  cpu_re  in  1  load request
  cpu_we  in  1  store request
  cpu_addr  in  32  byte address, word aligned
  cpu_wd  in  32  store data
  cpu_rd  out  32  load data
  cpu_stall  out  1  pipeline hold
  mem_req  out  1  memory transaction request
  mem_we  out  1  1 = block writeback, 0 = block fill
  mem_addr  out  32  block-aligned address (low OFF_BITS+2 bits zero)
  mem_wdata  out  BLOCK_W  victim block for writeback
  mem_rdata  in  BLOCK_W  fill block
  mem_ready  in  1  one-cycle completion pulse
  hit_cnt  out  32  hit counter (see Configuration)
  miss_cnt  out  32  miss counter (see Configuration)

Function
REQ-004 SHALL be 2-way set associative, write-back, write-allocate; per way per set: valid, dirty, tag, block; per set: one LRU bit naming the next victim way.
REQ-005 SHALL treat cpu_re and cpu_we both high as a store.
REQ-006 SHALL implement FSM IDLE, WRITEBACK, FILL; reset state IDLE.
REQ-007 IDLE, hit: cpu_stall=0; cpu_rd combinationally returns the addressed word of the hitting way; a store updates that word and sets dirty at the next posedge; the LRU bit becomes the non-hit way.
REQ-008 IDLE, miss (request active, no hit): cpu_stall=1 in the same cycle; victim = way0 if invalid, else way1 if invalid, else LRU way; next state WRITEBACK if victim is valid and dirty, else FILL.
REQ-009 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, set, 0}, mem_wdata=victim block; on mem_ready go to FILL.
REQ-010 FILL: mem_req=1, mem_we=0, mem_addr={request tag, set, 0}; on mem_ready write mem_rdata, tag, valid=1, dirty=0 into the victim way and go to IDLE; the retried access hits one cycle later (stores then merge per REQ-007).
REQ-011 SHALL hold cpu_stall=1 throughout WRITEBACK and FILL; the CPU holds cpu_addr/cpu_wd/cpu_re/cpu_we stable while stalled.
REQ-012 SHALL ignore mem_ready in IDLE; mem_req=0 and mem_we=0 in IDLE.
REQ-013 SHALL latch the victim way and set on the miss cycle, so FSM behaviour does not depend on inputs changing mid-transaction.
REQ-014 With no request active, cpu_stall=0 and cpu_rd is don't-care.

Reset
REQ-015 rst high at a posedge SHALL clear all valid, dirty and LRU bits and force IDLE; any WRITEBACK/FILL in progress is abandoned and mem_req=0 from the following cycle.
REQ-016 Tag and data arrays need not be reset; counters reset to 0.

Configuration
REQ-017 With D_CACHE_STATS_EN defined, hit_cnt increments once per IDLE hit cycle and miss_cnt once per miss detection in IDLE, both wrapping modulo 2^32.
REQ-018 Without D_CACHE_STATS_EN, hit_cnt and miss_cnt SHALL be tied to 0 and no counter registers exist.

Structure
REQ-019 Package d_cache_pkg SHALL hold the FSM state encoding and the constants ADDR_W=32 and WORD_W=32.
REQ-020 Sub-module d_cache_way (valid/dirty/tag/data storage plus hit compare for one way) SHALL be instantiated twice; the LRU bits and FSM live in d_cache_wb.

Verification (SET_BITS=8, OFF_BITS=2)
REQ-021 Cold miss: after reset, load 0x0000_1004 -> cpu_stall=1, mem_req=1, mem_we=0, mem_addr=0x0000_1000; mem_ready after 20 cycles with word1=0xDEADBEEF -> next cycle cpu_stall=0, cpu_rd=0xDEADBEEF.
REQ-022 Write hit: store 0x1234_5678 to 0x0000_1008 -> no mem_req, cpu_stall=0; load 0x0000_1008 returns 0x1234_5678.
REQ-023 LRU: fill 0x0000_1000 and 0x0000_2000 (clean, set 0), load 0x0000_1000 hit, load 0x0000_3000 -> evicts 0x2000 way, goes straight to FILL with mem_addr=0x0000_3000.
REQ-024 Dirty eviction: after REQ-022, make 0x1000 the LRU line, load 0x0000_3000 -> WRITEBACK with mem_we=1, mem_addr=0x0000_1000, mem_wdata word2=0x1234_5678, then FILL with mem_addr=0x0000_3000.
REQ-025 Reset mid-FILL: rst for one cycle -> mem_req=0 next cycle, state IDLE; reload 0x0000_1000 misses again.
REQ-026 Stats: 1 miss + 2 hits -> miss_cnt=1, hit_cnt=2 with D_CACHE_STATS_EN; both 0 without it.
